// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and sizing helpers for the branch resolve unit.
package branch_resolve_unit_pkg;

   localparam int unsigned BRU_NUM_WARPS = 4;
   localparam int unsigned BRU_XLEN      = 32;

   // Warp-id width: at least one bit even for a single warp.
   function automatic int unsigned bru_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned BRU_NW_WIDTH = bru_idx_width(BRU_NUM_WARPS);

   typedef enum logic [1:0] {
      BR_IDLE     = 2'd0,
      BR_PENDING  = 2'd1,
      BR_RESOLVED = 2'd2
   } br_state_e;

   typedef struct packed {
      logic [BRU_NW_WIDTH-1:0] wid;
      logic                    taken;
      logic [BRU_XLEN-1:0]     dest;
   } br_rsp_t;

endpackage

// File: rtl/br_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, pointer moves past the
// winner on an accepted grant, and a stalled grant is held until accepted.
module br_rr_arbiter import branch_resolve_unit_pkg::*; #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [N-1:0]  req_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          gnt_valid_o
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] lock_idx_q;
   logic          lock_q;
   int unsigned   cand;

   // First requester at or after the pointer wins; a held grant overrides.
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      gnt_o       = '0;
      cand        = 0;
      ptr_d       = ptr_q;
      for (int unsigned i = 0; i < N; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= N) cand = cand - N;
         if (!gnt_valid_o && req_i[IW'(cand)]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = IW'(cand);
         end
      end
      if (lock_q && req_i[lock_idx_q]) begin
         gnt_valid_o = 1'b1;
         gnt_idx_o   = lock_idx_q;
      end
      if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
      if (gnt_valid_o && en_i) ptr_d = IW'((32'(gnt_idx_o) + 32'd1) % N);
   end

   // Pointer and grant-hold registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         lock_q <= gnt_valid_o & ~en_i;
         if (gnt_valid_o && !en_i) lock_idx_q <= gnt_idx_o;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks one outstanding branch per warp, stalls its issue until resolved,
// and returns buffered outcomes to fetch round-robin over a valid/ready port.
module branch_resolve_unit import branch_resolve_unit_pkg::*; #(
   parameter  int unsigned NUM_WARPS = BRU_NUM_WARPS,
   parameter  int unsigned XLEN      = BRU_XLEN,
   localparam int unsigned NW_WIDTH  = bru_idx_width(NUM_WARPS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 br_issue_valid,
   input  logic [NW_WIDTH-1:0]  br_issue_wid,
   input  logic                 br_ctl_valid,
   input  logic [NW_WIDTH-1:0]  br_ctl_wid,
   input  logic                 br_ctl_taken,
   input  logic [XLEN-1:0]      br_ctl_dest,
   output logic [NUM_WARPS-1:0] stall_mask,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [NW_WIDTH-1:0]  rsp_wid,
   output logic                 rsp_taken,
   output logic [XLEN-1:0]      rsp_dest,
   output logic                 err
);

   br_state_e            state_q [NUM_WARPS];
   br_state_e            state_d [NUM_WARPS];
   logic [XLEN-1:0]      dest_q  [NUM_WARPS];
   logic [XLEN-1:0]      dest_d  [NUM_WARPS];
   logic [NUM_WARPS-1:0] taken_q, taken_d;
   logic                 err_q, err_d;

   logic [NUM_WARPS-1:0] req_c, gnt_c;
   logic [NW_WIDTH-1:0]  gnt_idx_c;
   logic                 gnt_valid_c, hs_c;
   logic                 same_wid_c, issue_bad_c, ctl_bad_c, issue_ok_c, ctl_ok_c;
   br_rsp_t              rsp_c;

   // Per-warp decode straight from the state registers.
   always_comb begin
      req_c      = '0;
      stall_mask = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         req_c[w]      = (state_q[w] == BR_RESOLVED);
         stall_mask[w] = (state_q[w] != BR_IDLE);
      end
   end

   br_rr_arbiter #(
      .N  (NUM_WARPS),
      .IW (NW_WIDTH)
   ) u_arb (
      .clk_i       (clk),
      .rst_ni      (reset),
      .req_i       (req_c),
      .en_i        (rsp_ready),
      .gnt_o       (gnt_c),
      .gnt_idx_o   (gnt_idx_c),
      .gnt_valid_o (gnt_valid_c)
   );

   // Classify this cycle's issue/resolve events; bad events are dropped.
   always_comb begin
      same_wid_c  = br_issue_valid & br_ctl_valid & (br_issue_wid == br_ctl_wid);
      issue_bad_c = br_issue_valid & (state_q[br_issue_wid] != BR_IDLE);
      ctl_bad_c   = br_ctl_valid & (state_q[br_ctl_wid] != BR_PENDING);
      issue_ok_c  = br_issue_valid & ~issue_bad_c & ~same_wid_c;
      ctl_ok_c    = br_ctl_valid & ~ctl_bad_c & ~same_wid_c;
      hs_c        = gnt_valid_c & rsp_ready;
   end

   // Next state: handshake, issue and resolve act independently per warp.
   always_comb begin
      state_d = state_q;
      dest_d  = dest_q;
      taken_d = taken_q;
      err_d   = err_q | issue_bad_c | ctl_bad_c | same_wid_c;
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (hs_c && gnt_c[w]) state_d[w] = BR_IDLE;
      end
      if (issue_ok_c) state_d[br_issue_wid] = BR_PENDING;
      if (ctl_ok_c) begin
         state_d[br_ctl_wid] = BR_RESOLVED;
         taken_d[br_ctl_wid] = br_ctl_taken;
         dest_d[br_ctl_wid]  = br_ctl_dest;
      end
   end

   // Warp state, outcome storage and sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            state_q[w] <= BR_IDLE;
            dest_q[w]  <= '0;
         end
         taken_q <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            state_q[w] <= state_d[w];
            dest_q[w]  <= dest_d[w];
         end
         taken_q <= taken_d;
         err_q   <= err_d;
      end
   end

   // Response payload of the granted warp.
   always_comb begin
      rsp_c       = '0;
      rsp_c.wid   = BRU_NW_WIDTH'(gnt_idx_c);
      rsp_c.taken = taken_q[gnt_idx_c];
      rsp_c.dest  = BRU_XLEN'(dest_q[gnt_idx_c]);
   end

   assign rsp_valid = gnt_valid_c;
   assign rsp_wid   = NW_WIDTH'(rsp_c.wid);
   assign rsp_taken = rsp_c.taken;
   assign rsp_dest  = XLEN'(rsp_c.dest);
   assign err       = err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed stimulus pushes
// hand-computed outcomes, a negedge monitor pops them on each handshake.
module tb_branch_resolve_unit;

   typedef struct {
      logic [1:0]  wid;
      logic        taken;
      logic [31:0] dest;
   } exp_t;

   logic        clk, reset;
   logic        br_issue_valid, br_ctl_valid, br_ctl_taken;
   logic [1:0]  br_issue_wid, br_ctl_wid;
   logic [31:0] br_ctl_dest;
   logic [3:0]  stall_mask;
   logic        rsp_valid, rsp_ready, rsp_taken, err;
   logic [1:0]  rsp_wid;
   logic [31:0] rsp_dest;

   exp_t exp_q[$];
   exp_t mon_e, hold_e;
   bit   hold_v;
   int   n_cmp = 0;
   int   n_err = 0;

   branch_resolve_unit dut (
      .clk            (clk),
      .reset          (reset),
      .br_issue_valid (br_issue_valid),
      .br_issue_wid   (br_issue_wid),
      .br_ctl_valid   (br_ctl_valid),
      .br_ctl_wid     (br_ctl_wid),
      .br_ctl_taken   (br_ctl_taken),
      .br_ctl_dest    (br_ctl_dest),
      .stall_mask     (stall_mask),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_wid        (rsp_wid),
      .rsp_taken      (rsp_taken),
      .rsp_dest       (rsp_dest),
      .err            (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, summary not printed");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] w, input logic t, input logic [31:0] d);
      exp_t e;
      e.wid   = w;
      e.taken = t;
      e.dest  = d;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic iv, input logic [1:0] iw, input logic cv,
                        input logic [1:0] cw, input logic ct, input logic [31:0] cd);
      br_issue_valid = iv;
      br_issue_wid   = iw;
      br_ctl_valid   = cv;
      br_ctl_wid     = cw;
      br_ctl_taken   = ct;
      br_ctl_dest    = cd;
      @(posedge clk);
      #1;
      br_issue_valid = 1'b0;
      br_ctl_valid   = 1'b0;
   endtask

   task automatic issue(input logic [1:0] w);
      drive(1'b1, w, 1'b0, 2'd0, 1'b0, 32'h0);
   endtask

   task automatic resolve(input logic [1:0] w, input logic t, input logic [31:0] d);
      drive(1'b0, 2'd0, 1'b1, w, t, d);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: pops on handshake, and checks payload stability while stalled.
   always @(negedge clk) begin
      if (!reset) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_wid",   64'(rsp_wid),   64'(hold_e.wid));
            chk("hold_taken", 64'(rsp_taken), 64'(hold_e.taken));
            chk("hold_dest",  64'(rsp_dest),  64'(hold_e.dest));
         end
         if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("rsp_wid",   64'(rsp_wid),   64'(mon_e.wid));
               chk("rsp_taken", 64'(rsp_taken), 64'(mon_e.taken));
               if (mon_e.taken) chk("rsp_dest", 64'(rsp_dest), 64'(mon_e.dest));
            end
         end
         hold_v       = rsp_valid && !rsp_ready;
         hold_e.wid   = rsp_wid;
         hold_e.taken = rsp_taken;
         hold_e.dest  = rsp_dest;
      end
   end

   initial begin
      reset          = 1'b0;
      rsp_ready      = 1'b1;
      br_issue_valid = 1'b0;
      br_issue_wid   = 2'd0;
      br_ctl_valid   = 1'b0;
      br_ctl_wid     = 2'd0;
      br_ctl_taken   = 1'b0;
      br_ctl_dest    = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_stall", 64'(stall_mask), 64'd0);
      chk("reset_valid", 64'(rsp_valid),  64'd0);
      chk("reset_err",   64'(err),        64'd0);
      reset = 1'b1;
      idle(1);

      // Single taken branch on warp 1.
      issue(2'd1);
      chk("t1_stall_issue", 64'(stall_mask), 64'h2);
      chk("t1_no_rsp",      64'(rsp_valid),  64'd0);
      idle(2);
      push(2'd1, 1'b1, 32'h8000_0100);
      resolve(2'd1, 1'b1, 32'h8000_0100);
      chk("t1_rsp_valid",   64'(rsp_valid),  64'd1);
      chk("t1_stall_held",  64'(stall_mask), 64'h2);
      idle(1);
      chk("t1_stall_clear", 64'(stall_mask), 64'h0);

      // Not-taken branch on warp 2.
      issue(2'd2);
      idle(1);
      push(2'd2, 1'b0, 32'h0000_1234);
      resolve(2'd2, 1'b0, 32'h0000_1234);
      chk("t2_stall_held",  64'(stall_mask), 64'h4);
      idle(1);
      chk("t2_stall_clear", 64'(stall_mask), 64'h0);

      // Warp 3 round trip brings the pointer back to warp 0.
      issue(2'd3);
      push(2'd3, 1'b1, 32'h0000_0010);
      resolve(2'd3, 1'b1, 32'h0000_0010);
      idle(1);
      chk("t3_stall_clear", 64'(stall_mask), 64'h0);

      // Fairness under backpressure, then wrap back to warp 0.
      rsp_ready = 1'b0;
      issue(2'd0);
      issue(2'd1);
      issue(2'd2);
      issue(2'd3);
      chk("fair_stall_all", 64'(stall_mask), 64'hF);
      resolve(2'd0, 1'b1, 32'h0000_1000);
      chk("fair_first_wid", 64'(rsp_wid), 64'd0);
      resolve(2'd3, 1'b1, 32'hFFFF_FFFC);
      resolve(2'd1, 1'b0, 32'hDEAD_BEEF);
      resolve(2'd2, 1'b1, 32'h0000_0004);
      idle(5);
      chk("fair_bp_wid", 64'(rsp_wid), 64'd0);
      push(2'd0, 1'b1, 32'h0000_1000);
      push(2'd1, 1'b0, 32'hDEAD_BEEF);
      push(2'd2, 1'b1, 32'h0000_0004);
      push(2'd3, 1'b1, 32'hFFFF_FFFC);
      push(2'd0, 1'b1, 32'h7FFF_FFF0);
      rsp_ready = 1'b1;
      idle(1);
      issue(2'd0);
      resolve(2'd0, 1'b1, 32'h7FFF_FFF0);
      idle(2);
      chk("fair_stall_clear", 64'(stall_mask), 64'h0);

      // Issue w3, resolve w0 and handshake w1 in one cycle.
      rsp_ready = 1'b0;
      issue(2'd1);
      issue(2'd0);
      push(2'd1, 1'b1, 32'h0000_0A00);
      resolve(2'd1, 1'b1, 32'h0000_0A00);
      chk("cc_grant_w1", 64'(rsp_wid), 64'd1);
      rsp_ready = 1'b1;
      push(2'd0, 1'b0, 32'h0000_0B00);
      drive(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 32'h0000_0B00);
      chk("cc_stall",     64'(stall_mask), 64'h9);
      chk("cc_err",       64'(err),        64'd0);
      chk("cc_grant_w0",  64'(rsp_wid),    64'd0);
      idle(1);
      chk("cc_stall_w3",  64'(stall_mask), 64'h8);
      push(2'd3, 1'b1, 32'h0000_0C00);
      resolve(2'd3, 1'b1, 32'h0000_0C00);
      idle(1);
      chk("cc_stall_clear", 64'(stall_mask), 64'h0);

      // Protocol errors: resolve while idle, double issue, same-warp collision.
      chk("err_before", 64'(err), 64'd0);
      resolve(2'd2, 1'b1, 32'h0000_0DDD);
      chk("err_ctl_idle",   64'(err),        64'd1);
      chk("err_ctl_state",  64'(stall_mask), 64'h0);
      issue(2'd0);
      issue(2'd0);
      chk("err_double_iss", 64'(err),        64'd1);
      chk("err_iss_state",  64'(stall_mask), 64'h1);
      drive(1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 32'h0000_0EEE);
      chk("err_collide_st", 64'(stall_mask), 64'h1);
      push(2'd0, 1'b1, 32'h0000_0044);
      resolve(2'd0, 1'b1, 32'h0000_0044);
      idle(1);
      chk("err_sticky",     64'(err),        64'd1);
      chk("err_stall_clr",  64'(stall_mask), 64'h0);

      // A stalled grant is not preempted by a later, nearer resolve.
      rsp_ready = 1'b0;
      issue(2'd3);
      issue(2'd2);
      resolve(2'd3, 1'b1, 32'h0000_3330);
      chk("hold_grant_w3", 64'(rsp_wid), 64'd3);
      resolve(2'd2, 1'b1, 32'h0000_2220);
      chk("hold_keep_w3",  64'(rsp_wid), 64'd3);
      idle(2);
      push(2'd3, 1'b1, 32'h0000_3330);
      push(2'd2, 1'b1, 32'h0000_2220);
      rsp_ready = 1'b1;
      idle(2);
      chk("hold_stall_clr", 64'(stall_mask), 64'h0);

      // Async reset mid-operation discards everything.
      rsp_ready = 1'b0;
      issue(2'd0);
      issue(2'd1);
      issue(2'd2);
      resolve(2'd0, 1'b1, 32'h0000_5550);
      resolve(2'd1, 1'b1, 32'h0000_6660);
      chk("rst_pre_valid", 64'(rsp_valid),  64'd1);
      chk("rst_pre_stall", 64'(stall_mask), 64'h7);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_stall", 64'(stall_mask), 64'h0);
      chk("rst_valid", 64'(rsp_valid),  64'd0);
      chk("rst_err",   64'(err),        64'd0);
      idle(2);
      reset     = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         chk("post_rst_valid", 64'(rsp_valid),  64'd0);
         chk("post_rst_stall", 64'(stall_mask), 64'h0);
      end

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits directly downstream of the ALU unit's branch_ctl output and upstream of the fetch/warp scheduler.
- Tracks one outstanding branch per warp and holds that warp's issue stall until the branch resolves.
- Buffers each resolved outcome (taken, dest) and returns the outcomes to fetch, one per cycle, through a round-robin valid/ready port.
- branch_ctl has no ready signal, so the block must never drop a resolution.

Parameters:
- NUM_WARPS, 4, number of warps; must be ≥1 and a power of 2.
- XLEN, 32, PC width.
- NW_WIDTH, max(1, clog2(NUM_WARPS)), warp id width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- br_issue_valid  in  1  a branch for warp br_issue_wid is issuing this cycle.
- br_issue_wid  in  NW_WIDTH  issuing warp id.
- br_ctl_valid  in  1  branch resolved (from ALU branch_ctl.valid).
- br_ctl_wid  in  NW_WIDTH  resolving warp.
- br_ctl_taken  in  1  branch taken.
- br_ctl_dest  in  XLEN  target PC.
- stall_mask  out  NUM_WARPS  bit w=1: warp w must not issue.
- rsp_valid  out  1  outcome available to fetch.
- rsp_ready  in  1  fetch accepts the outcome.
- rsp_wid  out  NW_WIDTH  warp of the outcome.
- rsp_taken  out  1  taken flag.
- rsp_dest  out  XLEN  target PC; meaningful only when rsp_taken=1.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Per-warp state is 2 bits: IDLE, PENDING, RESOLVED. Each warp also holds taken_r and dest_r registers.
- Reset (async, reset=0):
  - all states IDLE; stall_mask=0; rsp_valid=0; err=0.
  - taken_r, dest_r, and the arbiter pointer are cleared to 0.
- Reset mid-operation discards all pending and resolved entries. No response is emitted after reset deasserts until a new issue/resolve occurs.
- State transitions:
  - IDLE → PENDING on br_issue_valid with wid=w.
  - PENDING → RESOLVED on br_ctl_valid with wid=w; latches taken and dest.
  - RESOLVED → IDLE on rsp_valid & rsp_ready with rsp_wid=w.
- stall_mask[w] = (state[w] != IDLE), decoded from registers with no combinational input path.
  - Issue at cycle T sets the stall bit visible at T+1.
  - The stall stays high until the cycle after the response handshake.
- Response arbitration:
  - Round-robin over warps in RESOLVED.
  - rsp_* are combinational from the state registers and pointer. A resolve at cycle T makes rsp_valid visible at T+1 at the earliest.
  - The pointer advances to grant+1 (mod NUM_WARPS) only on a handshake.
  - rsp_wid, rsp_taken, and rsp_dest hold stable while rsp_valid=1 and rsp_ready=0.
- Not-taken branches still produce a response (rsp_taken=0) so fetch can resume the warp.
- Simultaneous events:
  - Issue, resolve, and handshake in the same cycle on distinct warps all take effect independently.
  - Resolve of warp A and handshake of warp B in the same cycle: both apply.
- Errors (set err=1, sticky until reset; the offending event is otherwise ignored):
  - br_issue_valid for a warp not in IDLE.
  - br_ctl_valid for a warp not in PENDING.
  - Issue and resolve targeting the same warp in the same cycle.
- Capacity: at most one entry per warp and the issue stall guarantees no overflow, so no full condition exists.
- Empty: no warp in RESOLVED → rsp_valid=0 and the pointer holds.
- dest is stored at full XLEN with no truncation.

Decomposition:
- Shared package holds:
  - the br_state enum (IDLE=2'd0, PENDING=2'd1, RESOLVED=2'd2);
  - the br_rsp struct {wid, taken, dest}.
- One sub-module: br_rr_arbiter (NUM_WARPS requests, one-hot grant plus index, pointer update on an enable input).
- Everything else is flat in branch_resolve_unit.

Test Plan:
- Single taken branch:
  - Stimulus: issue wid=1 at T0; ctl wid=1 taken=1 dest=0x80000100 at T3; rsp_ready=1.
  - Response: stall_mask=4'b0010 from T1; rsp_valid/wid=1/taken=1/dest=0x80000100 at T4; stall_mask=0 at T5.
- Not-taken:
  - Stimulus: issue wid=2; ctl wid=2 taken=0 dest=0x1234.
  - Response: rsp_taken=0 with wid=2; stall bit 2 clears after the handshake.
- Fairness under backpressure:
  - Stimulus: resolve warps 0–3 in the same window with rsp_ready=0 for 5 cycles, then ready=1.
  - Response: outputs stay stable during backpressure; grants come out in order 0,1,2,3; the pointer then wraps and the next resolved warp 0 is served after 3.
- Concurrent events:
  - Stimulus: in one cycle, issue wid=3, resolve wid=0, and handshake wid=1.
  - Response: all three transitions occur; err stays 0.
- Protocol errors:
  - Stimulus: resolve wid=2 while IDLE; separately, issue wid=0 while PENDING.
  - Response: err=1 and sticky; warp state is unchanged.
- Async reset mid-operation:
  - Stimulus: assert reset low between clock edges while warps 0 and 1 are RESOLVED and warp 2 is PENDING.
  - Response: stall_mask=0, rsp_valid=0, err=0 immediately; no response after release.
